// File: rtl/mux_nto1_pipe.sv
// N:1 channel multiplexer feeding a single registered valid/ready stage.
// The stage carries one word, holds it under backpressure and counts pops.
module mux_nto1_pipe #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = 2,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sel_err,
   output logic [CNT_W-1:0]   xfer_cnt
);

   logic [WIDTH-1:0] data_p0;
   logic             vld_p0;
   logic             sel_ok_p0;
   logic             stage_free;
   logic             load;
   logic             pop;

   logic [WIDTH-1:0] data_p1;
   logic             vld_p1;
   logic             err_p1;
   logic [CNT_W-1:0] cnt_p1;

   // Out-of-range selects exist only when N does not fill the select space.
   assign sel_ok_p0  = ({1'b0, sel} < (SEL_W+1)'(N));
   assign stage_free = !vld_p1 || out_ready;

   always_comb begin
      data_p0  = '0;
      vld_p0   = 1'b0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == SEL_W'(i)) begin
            data_p0     = in_data[i*WIDTH +: WIDTH];
            vld_p0      = in_valid[i];
            in_ready[i] = stage_free && sel_ok_p0;
         end
      end
   end

   assign load = vld_p0 && stage_free && sel_ok_p0;
   assign pop  = vld_p1 && out_ready;

   // ---- p0 -> p1 register boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         err_p1  <= 1'b0;
         cnt_p1  <= '0;
      end else begin
         err_p1 <= !sel_ok_p0;
         if (load) begin
            data_p1 <= data_p0;
            vld_p1  <= 1'b1;
         end else if (pop) begin
            vld_p1  <= 1'b0;
         end
         if (pop)
            cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
   end

   assign out_data  = data_p1;
   assign out_valid = vld_p1;
   assign sel_err   = err_p1;
   assign xfer_cnt  = cnt_p1;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: a 4-channel instance for select,
// backpressure and streaming, a 3-channel 4-bit-counter instance for bad select and wrap.
module tb_mux_nto1_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // instance A: WIDTH=8 N=4 SEL_W=2 CNT_W=16
   logic [31:0] a_in_data;
   logic [3:0]  a_in_valid;
   logic [3:0]  a_in_ready;
   logic [1:0]  a_sel;
   logic [7:0]  a_out_data;
   logic        a_out_valid;
   logic        a_out_ready;
   logic        a_sel_err;
   logic [15:0] a_xfer_cnt;

   // instance B: WIDTH=8 N=3 SEL_W=2 CNT_W=4
   logic [23:0] b_in_data;
   logic [2:0]  b_in_valid;
   logic [2:0]  b_in_ready;
   logic [1:0]  b_sel;
   logic [7:0]  b_out_data;
   logic        b_out_valid;
   logic        b_out_ready;
   logic        b_sel_err;
   logic [3:0]  b_xfer_cnt;

   int checks = 0;
   int errors = 0;

   mux_nto1_pipe #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .sel(a_sel), .out_data(a_out_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .sel_err(a_sel_err), .xfer_cnt(a_xfer_cnt)
   );

   mux_nto1_pipe #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .sel_err(b_sel_err), .xfer_cnt(b_xfer_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      a_in_data   = '0;
      a_in_valid  = '0;
      a_sel       = '0;
      a_out_ready = 1'b0;
      b_in_data   = '0;
      b_in_valid  = '0;
      b_sel       = '0;
      b_out_ready = 1'b0;

      tick();
      tick();
      chk("rst_a_valid", 32'(a_out_valid), 32'd0);
      chk("rst_a_data",  32'(a_out_data),  32'd0);
      chk("rst_a_cnt",   32'(a_xfer_cnt),  32'd0);
      chk("rst_b_err",   32'(b_sel_err),   32'd0);
      rst_n = 1'b1;
      tick();

      // basic select: channel 2 carries A5
      a_in_data   = 32'h00A5_0000;
      a_in_valid  = 4'b0100;
      a_sel       = 2'd2;
      a_out_ready = 1'b1;
      #1;
      chk("sel_ready", 32'(a_in_ready), 32'b0100);
      tick();
      chk("sel_data",  32'(a_out_data),  32'hA5);
      chk("sel_valid", 32'(a_out_valid), 32'd1);
      chk("sel_cnt",   32'(a_xfer_cnt),  32'd0);

      // backpressure while sel moves to channel 1 (3C waiting)
      a_out_ready = 1'b0;
      a_sel       = 2'd1;
      a_in_data   = 32'h0000_3C00;
      a_in_valid  = 4'b0010;
      #1;
      chk("bp_ready", 32'(a_in_ready), 32'd0);
      tick();
      chk("bp_data1", 32'(a_out_data), 32'hA5);
      tick();
      chk("bp_data2",  32'(a_out_data),  32'hA5);
      chk("bp_valid",  32'(a_out_valid), 32'd1);
      chk("bp_cnt",    32'(a_xfer_cnt),  32'd0);
      a_out_ready = 1'b1;
      #1;
      chk("bp_ready_up", 32'(a_in_ready), 32'b0010);
      tick();
      chk("popload_data",  32'(a_out_data),  32'h3C);
      chk("popload_valid", 32'(a_out_valid), 32'd1);
      chk("popload_cnt",   32'(a_xfer_cnt),  32'd1);
      a_in_valid = 4'b0000;
      tick();
      chk("drain_valid", 32'(a_out_valid), 32'd0);
      chk("drain_data",  32'(a_out_data),  32'h3C);
      chk("drain_cnt",   32'(a_xfer_cnt),  32'd2);

      // streaming 0..7 on channel 0
      a_sel = 2'd0;
      for (int k = 0; k < 8; k++) begin
         a_in_data  = 32'(k);
         a_in_valid = 4'b0001;
         tick();
         chk("stream_data",  32'(a_out_data),  32'(k));
         chk("stream_valid", 32'(a_out_valid), 32'd1);
         chk("stream_cnt",   32'(a_xfer_cnt),  32'(2 + k));
      end
      a_in_valid = 4'b0000;
      tick();
      chk("stream_end_valid", 32'(a_out_valid), 32'd0);
      chk("stream_end_cnt",   32'(a_xfer_cnt),  32'd10);

      // bad select on the 3-channel instance
      b_in_data   = 24'h33_22_11;
      b_in_valid  = 3'b111;
      b_sel       = 2'd3;
      b_out_ready = 1'b1;
      #1;
      chk("bad_ready", 32'(b_in_ready), 32'd0);
      tick();
      chk("bad_err1",   32'(b_sel_err),   32'd1);
      chk("bad_valid1", 32'(b_out_valid), 32'd0);
      tick();
      chk("bad_err2",   32'(b_sel_err),   32'd1);
      chk("bad_valid2", 32'(b_out_valid), 32'd0);
      b_sel = 2'd0;
      #1;
      chk("bad_ready0", 32'(b_in_ready), 32'b001);
      tick();
      chk("bad_err_clr", 32'(b_sel_err),   32'd0);
      chk("bad_data",    32'(b_out_data),  32'h11);
      chk("bad_valid",   32'(b_out_valid), 32'd1);
      chk("bad_cnt",     32'(b_xfer_cnt),  32'd0);

      // counter wrap: one pop per edge from here on
      for (int p = 1; p <= 17; p++) begin
         tick();
         chk("wrap_cnt", 32'(b_xfer_cnt), 32'(p % 16));
      end
      b_in_valid = 3'b000;
      b_sel      = 2'd3;
      tick();
      chk("wrap_last_cnt", 32'(b_xfer_cnt), 32'd2);
      chk("wrap_err",      32'(b_sel_err),  32'd1);

      // asynchronous reset with a held word, away from any clock edge
      a_in_data   = 32'h0000_0055;
      a_in_valid  = 4'b0001;
      a_out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
      chk("pre_rst_data",  32'(a_out_data),  32'h55);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_a_valid", 32'(a_out_valid), 32'd0);
      chk("arst_a_data",  32'(a_out_data),  32'd0);
      chk("arst_a_cnt",   32'(a_xfer_cnt),  32'd0);
      chk("arst_b_err",   32'(b_sel_err),   32'd0);
      chk("arst_b_cnt",   32'(b_xfer_cnt),  32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
